// File: rtl/filter_pkg.sv
// Shared types, widths and the Q1.15 output saturation helper for the FIR stages.
package filter_pkg;

   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int ACC_W  = 40;
   localparam int FRAC   = 15;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } fsm_state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

   // Drop the fractional bits by arithmetic shift (truncation), then clamp to Q1.15.
   function automatic logic signed [DATA_W-1:0] sat_q15(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] shifted;
      shifted = acc >>> FRAC;
      if (shifted > SAT_MAX) begin
         return SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         return SAT_MIN[DATA_W-1:0];
      end else begin
         return shifted[DATA_W-1:0];
      end
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared signed multiply-accumulate unit; one product per enabled cycle.
// acc_nxt_o exposes the value the accumulator takes at the coming edge so the
// sequencer can capture the final sum without an extra cycle.
module fir_mac
   import filter_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic signed [DATA_W-1:0] x_i,
   input  logic signed [COEF_W-1:0] c_i,
   output logic signed [ACC_W-1:0]  acc_nxt_o
);

   logic signed [DATA_W+COEF_W-1:0] prod;
   logic signed [ACC_W-1:0]         prod_ext;
   logic signed [ACC_W-1:0]         acc_q;
   logic signed [ACC_W-1:0]         acc_d;

   assign prod     = x_i * c_i;
   assign prod_ext = {{(ACC_W - DATA_W - COEF_W){prod[DATA_W+COEF_W-1]}}, prod};

   // Next accumulator value: clear wins over accumulate.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + prod_ext;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_nxt_o = acc_d;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: holds the tap delay line, walks one shared
// MAC across all taps using an external combinational coefficient ROM, and
// presents the saturated result on a valid/ready output.
module fir_tap_sequencer
   import filter_pkg::*;
#(
   parameter int NTAPS = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic signed [DATA_W-1:0]   sample_in,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic                       flush,
   output logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   output logic signed [DATA_W-1:0]   out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy
);

   localparam int                 TAP_W    = $clog2(NTAPS);
   localparam logic [TAP_W-1:0]   LAST_TAP = TAP_W'(NTAPS - 1);

   fsm_state_t                 state_q;
   logic [TAP_W-1:0]           tap_q;
   logic signed [DATA_W-1:0]   x_q [NTAPS];
   logic signed [DATA_W-1:0]   out_data_q;
   logic                       out_valid_q;

   logic                       accept;
   logic                       mac_en;
   logic signed [ACC_W-1:0]    acc_nxt;

   // flush takes priority over a new sample in IDLE
   assign accept       = (state_q == IDLE) && !flush && sample_valid;
   assign mac_en       = (state_q == MAC);
   assign sample_ready = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign coef_addr    = mac_en ? tap_q : '0;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;

   fir_mac u_mac (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_i     (accept),
      .en_i      (mac_en),
      .x_i       (x_q[tap_q]),
      .c_i       (coef_data),
      .acc_nxt_o (acc_nxt)
   );

   // Sequencer FSM with delay line, tap counter and registered output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tap_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int k = 0; k < NTAPS; k++) begin
            x_q[k] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (flush) begin
                  for (int k = 0; k < NTAPS; k++) begin
                     x_q[k] <= '0;
                  end
               end else if (sample_valid) begin
                  for (int k = NTAPS - 1; k > 0; k--) begin
                     x_q[k] <= x_q[k-1];
                  end
                  x_q[0]  <= sample_in;
                  tap_q   <= '0;
                  state_q <= MAC;
               end
            end
            MAC: begin
               if (tap_q == LAST_TAP) begin
                  // acc_nxt already includes the last tap's product
                  tap_q       <= '0;
                  out_data_q  <= sat_q15(acc_nxt);
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end else begin
                  tap_q <= tap_q + 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed + randomized bench for fir_tap_sequencer against a sum-of-products model.
module tb_fir_tap_sequencer;

   localparam int NTAPS = 5;

   logic                clk;
   logic                reset_n;
   logic signed [15:0]  sample_in;
   logic                sample_valid;
   logic                sample_ready;
   logic                flush;
   logic [2:0]          coef_addr;
   logic signed [15:0]  coef_data;
   logic [15:0]         out_data;
   logic                out_valid;
   logic                out_ready;
   logic                busy;

   logic signed [15:0]  rom [NTAPS];
   logic signed [15:0]  hist [$];
   int                  n_tests;
   int                  n_fail;
   logic [15:0]         obs;
   logic [15:0]         imp_exp [9];

   assign coef_data = (coef_addr < 3'(NTAPS)) ? rom[coef_addr] : 16'sd0;

   fir_tap_sequencer #(.NTAPS(NTAPS)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .flush        (flush),
      .coef_addr    (coef_addr),
      .coef_data    (coef_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: y = clamp((sum_k x[k]*c[k]) >>> 15), x[0] newest, missing history is zero.
   function automatic logic [15:0] model_out();
      longint acc;
      acc = 0;
      for (int k = 0; k < hist.size() && k < NTAPS; k++) begin
         acc += longint'(hist[k]) * longint'(rom[k]);
      end
      acc = acc >>> 15;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      return acc[15:0];
   endfunction

   task automatic set_rom(input logic signed [15:0] v);
      for (int k = 0; k < NTAPS; k++) rom[k] = v;
   endtask

   // One full sample->result transaction with optional output backpressure.
   task automatic transact(input logic signed [15:0] s, input int hold, output logic [15:0] res);
      logic [15:0] exp_d;
      int          n;
      for (int i = 0; i < 50 && sample_ready !== 1'b1; i++) @(negedge clk);
      check("ready_before_accept", 32'(sample_ready), 32'd1);
      sample_in    = s;
      sample_valid = 1'b1;
      out_ready    = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      hist.push_front(s);
      if (hist.size() > NTAPS) void'(hist.pop_back());
      exp_d = model_out();
      check("busy_in_mac", 32'(busy), 32'd1);
      check("not_ready_in_mac", 32'(sample_ready), 32'd0);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         if (n < NTAPS) check("coef_addr_walk", 32'(coef_addr), 32'(n));
         n++;
         @(posedge clk); #1;
      end
      check("out_valid_rise", 32'(out_valid), 32'd1);
      check("latency", 32'(n), 32'(NTAPS));
      check("out_data", 32'(out_data), 32'(exp_d));
      check("coef_addr_out", 32'(coef_addr), 32'd0);
      res = out_data;
      if (hold > 0) begin
         out_ready    = 1'b0;
         sample_valid = 1'b1;
         sample_in    = 16'($urandom);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_data_stable", 32'(out_data), 32'(res));
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_not_ready", 32'(sample_ready), 32'd0);
         end
         sample_valid = 1'b0;
         out_ready    = 1'b1;
      end
      @(posedge clk); #1;
      check("handshake_valid_low", 32'(out_valid), 32'd0);
      check("ready_after_handshake", 32'(sample_ready), 32'd1);
      check("data_held_in_idle", 32'(out_data), 32'(res));
   endtask

   task automatic do_flush();
      flush        = 1'b1;
      sample_valid = 1'b1;
      sample_in    = 16'($urandom);
      @(posedge clk); #1;
      flush        = 1'b0;
      sample_valid = 1'b0;
      check("flush_not_accepted_busy", 32'(busy), 32'd0);
      check("flush_ready", 32'(sample_ready), 32'd1);
      hist.delete();
   endtask

   task automatic run_impulse(input string tag);
      set_rom(16'sh2000);
      for (int i = 0; i < 9; i++) begin
         transact((i == 0) ? 16'sh4000 : 16'sh0000, 0, obs);
         check(tag, 32'(obs), 32'(imp_exp[i]));
      end
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      reset_n      = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      flush        = 1'b0;
      out_ready    = 1'b1;
      set_rom(16'sh2000);
      for (int i = 0; i < 9; i++) imp_exp[i] = (i < 5) ? 16'h1000 : 16'h0000;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_sample_ready", 32'(sample_ready), 32'd1);
      check("rst_coef_addr", 32'(coef_addr), 32'd0);

      // impulse response
      run_impulse("impulse");

      // backpressure, then immediate next accept
      transact(16'sh1234, 4, obs);
      transact(16'sh0000, 0, obs);

      // flush beats a simultaneous sample
      for (int i = 0; i < 3; i++) transact(16'sh4000, 0, obs);
      do_flush();
      transact(16'sh0000, 0, obs);
      check("flush_zero_out", 32'(obs), 32'h0000);

      // saturation
      set_rom(16'sh7FFF);
      for (int i = 0; i < 5; i++) transact(16'sh7FFF, 0, obs);
      check("sat_pos", 32'(obs), 32'h7FFF);
      for (int i = 0; i < 5; i++) transact(-16'sh8000, 0, obs);
      check("sat_neg", 32'(obs), 32'h8000);

      // reset in the third MAC cycle
      set_rom(16'sh2000);
      sample_in    = 16'sh4000;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("third_mac_tap", 32'(coef_addr), 32'd2);
      reset_n = 1'b0;
      #2;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      hist.delete();
      @(posedge clk); #1;
      check("midrst_ready", 32'(sample_ready), 32'd1);
      check("midrst_busy_after", 32'(busy), 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("midrst_no_output", 32'(out_valid), 32'd0);
      run_impulse("impulse_after_reset");

      // randomized traffic against the model
      for (int k = 0; k < NTAPS; k++) rom[k] = 16'($urandom);
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0: do_flush();
            1: for (int k = 0; k < NTAPS; k++) rom[k] = 16'($urandom);
            default: ;
         endcase
         transact(16'($urandom), int'($urandom_range(0, 3)), obs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Time-multiplexed FIR controller for the channel-strip filter stage. It accepts one signed 16-bit audio sample per handshake and holds the tap delay line. It walks a single shared multiply-accumulate unit across all taps, reading coefficients from an external coefficient ROM. It then presents the saturated filtered sample on a valid/ready output port, so the lowpass and other FIR stages can share one multiplier per stage instead of one per tap.

## Interface
- NTAPS, 5, number of FIR taps (≥2)
- DATA_W, 16, sample width, signed Q1.15
- COEF_W, 16, coefficient width, signed Q1.15
- ACC_W, 40, accumulator width, signed

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- sample_in  in  DATA_W  input sample
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  block can accept a sample
- flush  in  1  zero the delay line
- coef_addr  out  $clog2(NTAPS)  tap index to coefficient ROM
- coef_data  in  COEF_W  coefficient for coef_addr, combinational (same-cycle) ROM
- out_data  out  DATA_W  filtered sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in MAC or OUT state

## Operation
- FSM states are IDLE, MAC and OUT.
- IDLE:
  - sample_ready=1.
  - flush=1 clears all delay-line entries to 0 and stays in IDLE. flush has priority over a simultaneous sample_valid, which is not accepted.
  - Otherwise, sample_valid=1 shifts the delay line (x[k]←x[k-1], x[0]←sample_in), clears acc, sets tap=0 and moves to MAC.
- MAC:
  - coef_addr=tap.
  - acc ← acc + x[tap]·coef_data. The product is a 2·DATA_W-bit signed value, sign-extended to ACC_W.
  - tap increments each cycle. After tap=NTAPS-1 the state moves to OUT.
  - flush and sample_valid are ignored (sample_ready=0).
- OUT:
  - out_valid=1 and out_data=sat(acc >>> 15) are held stable.
  - sat clamps to [0x8000, 0x7FFF]. Truncation is used (arithmetic shift), with no rounding.
  - On out_valid && out_ready the state returns to IDLE.
- coef_addr=0 outside MAC.
- The accumulator cannot overflow for NTAPS ≤ 256 at ACC_W=40, so no internal saturation is applied.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, delay line=0, acc=0, tap=0.
  - out_valid=0, out_data=0, busy=0.
  - sample_ready=1 and coef_addr=0 once reset is released.
- Latency: accept at edge N gives MAC in cycles N+1..N+NTAPS and out_valid=1 from cycle N+NTAPS+1.
- Throughput: one sample per NTAPS+2 cycles with out_ready held high.
- out_data is registered; it updates only on entry to OUT and holds its value in IDLE.
- Backpressure: while out_ready=0 in OUT, out_data, out_valid and the delay line are frozen, and sample_ready=0.
- Output handshake and next input: the output handshake completes at edge M. IDLE follows, so the earliest next accept is edge M+1. There is no same-cycle bypass.
- Reset mid-MAC or mid-OUT aborts the computation. No partial output is emitted and the delay line is cleared.

## Structure
- Package filter_pkg:
  - DATA_W, COEF_W, ACC_W and FRAC=15 localparams.
  - enum fsm_state_t {IDLE, MAC, OUT}.
  - Function sat_q15(acc) returning DATA_W.
- Sub-module fir_mac contains the signed multiplier, the ACC_W accumulator, and clear/enable inputs. The top level holds the FSM, tap counter, delay line and output register.
- The coefficient ROM is external, so the same sequencer serves the lowpass and highpass instances.

## Test plan
- Impulse:
  - ROM all 0x2000, NTAPS=5.
  - Feed 0x4000 then eight samples of 0x0000, out_ready=1.
  - Expect outputs 0x1000 ×5 then 0x0000 ×4.
  - Each out_valid rises 6 cycles after its accept.
- Positive saturation: ROM all 0x7FFF, feed 0x7FFF ×5 → fifth output 0x7FFF, never wraps negative.
- Negative saturation: ROM all 0x7FFF, feed 0x8000 ×5 → fifth output 0x8000.
- Backpressure:
  - Hold out_ready=0 for 4 cycles in OUT with sample_valid=1.
  - Expect out_data stable, sample_ready=0 and no sample consumed.
  - Release → handshake, then accept on the next cycle.
- Flush:
  - Load 0x4000 ×3.
  - Assert flush together with sample_valid in IDLE → sample not accepted.
  - Next sample 0x0000 yields output 0x0000.
- Reset mid-MAC:
  - Assert reset_n=0 on the third MAC cycle.
  - Expect out_valid=0, busy=0 and sample_ready=1 after release.
  - Next impulse response matches the first scenario exactly.
